vx_gbar_responder: RTL and testbench
====================================

VX_GBAR_RESPONDER -- requirements
Module: vx_gbar_responder

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of core request ports (1..32).
REQ-002 SHALL have parameter NUM_BARRIERS, default 8: number of global barrier ids (power of two).
REQ-003 SHALL define NC_WIDTH = max(1, clog2(NUM_CORES)) and NB_WIDTH = max(1, clog2(NUM_BARRIERS)).
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port reset, input, 1: reset (synchronous, active-high).
REQ-006 SHALL have port req_valid, input, NUM_CORES: per-core barrier arrival request.
REQ-007 SHALL have port req_id, input, NUM_CORES x NB_WIDTH: per-core barrier id.
REQ-008 SHALL have port req_size_m1, input, NUM_CORES x NC_WIDTH: participating core count minus one.
REQ-009 SHALL have port req_core_id, input, NUM_CORES x NC_WIDTH: requester core id.
REQ-010 SHALL have port req_ready, output, NUM_CORES: per-core accept (grant).
REQ-011 SHALL have port rsp_valid, output, 1: barrier release broadcast to all cores.
REQ-012 SHALL have port rsp_id, output, NB_WIDTH: released barrier id.
REQ-013 SHALL have port dup_err, output, 1: one-cycle pulse on duplicate arrival.

Function
REQ-014 SHALL accept at most one request per cycle; req_ready is one-hot or zero; fire = req_valid[i] & req_ready[i].
REQ-015 SHALL grant round-robin: priority starts at core (rr_ptr); after a fire by core g, rr_ptr = (g+1) mod NUM_CORES; no fire leaves rr_ptr unchanged.
REQ-016 SHALL keep, per barrier b, an arrival mask arrive[b] of NUM_CORES bits, indexed by req_core_id.
REQ-017 SHALL, on fire with id b and core c, compute next = arrive[b] | (1<<c); if popcount(next) == req_size_m1+1 (NC_WIDTH+1-bit compare) then clear arrive[b] and release b, else arrive[b] <= next.
REQ-018 SHALL register the release: rsp_valid=1 and rsp_id=b in the cycle after the fire (latency 1), for exactly one cycle.
REQ-019 SHALL drive rsp_valid=0 in every cycle without a release; rsp_id holds its last value.
REQ-020 SHALL treat a fire whose core bit is already set in arrive[b] as duplicate: mask unchanged, no release, dup_err pulses 1 cycle after the fire.
REQ-021 SHALL, when req_size_m1 == 0, release on the first arrival (single-core barrier).
REQ-022 SHALL keep barriers independent: a release of b never alters arrive[b'] for b' != b.
REQ-023 SHALL allow back-to-back releases on consecutive cycles, including same id re-armed immediately after release.
REQ-024 SHALL not depend on req_ready for req_valid (no combinational loop from req_ready to req_valid).

Reset
REQ-025 SHALL, on reset, clear all arrive masks, rr_ptr=0, rsp_valid=0, rsp_id=0, dup_err=0, req_ready=0.
REQ-026 SHALL discard any partially collected barrier when reset asserts mid-operation; no release issues for it afterward.

Configuration
REQ-027 SHALL support macro GBAR_PERF_EN: when defined, add outputs perf_releases (32-bit, +1 per release, wraps) and perf_wait_cycles (32-bit, +1 per cycle any arrive mask is nonzero, wraps), both reset to 0; when undefined, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-028 SHALL verify: NUM_CORES=4, cores 0,1,2,3 arrive on id 2 with size_m1=3 on cycles 1..4 -> rsp_valid=1, rsp_id=2 on cycle 5 only; arrive[2]=0.
REQ-029 SHALL verify: all 4 cores hold req_valid=1 continuously from rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-030 SHALL verify: core 1 arrives twice on id 0 (size_m1=1) -> dup_err pulses after second fire, no release; core 0 then arrives -> release id 0.
REQ-031 SHALL verify: interleaved ids 1 and 5 (size_m1=1 each) from cores 0/2 and 1/3 -> two releases, ids in completion order, masks independent.
REQ-032 SHALL verify: reset asserted after 2 of 4 arrivals on id 3 -> no rsp_valid ever; fresh 4 arrivals then release exactly once.
REQ-033 SHALL verify (GBAR_PERF_EN): REQ-028 sequence -> perf_releases=1, perf_wait_cycles=3.

Source files
------------

// File: rtl/vx_gbar_responder.sv
// Global barrier responder: round-robin accepts one core arrival per cycle,
// tracks per-barrier arrival masks and broadcasts a registered release.
// Optional macro GBAR_PERF_EN adds perf_releases / perf_wait_cycles counters.
module vx_gbar_responder #(
   parameter  int NUM_CORES    = 4,
   parameter  int NUM_BARRIERS = 8,
   localparam int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
   localparam int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_CORES-1:0]                req_valid,
   input  logic [NUM_CORES-1:0][NB_WIDTH-1:0]  req_id,
   input  logic [NUM_CORES-1:0][NC_WIDTH-1:0]  req_size_m1,
   input  logic [NUM_CORES-1:0][NC_WIDTH-1:0]  req_core_id,
   output logic [NUM_CORES-1:0]                req_ready,
   output logic                                rsp_valid,
   output logic [NB_WIDTH-1:0]                 rsp_id,
   output logic                                dup_err
`ifdef GBAR_PERF_EN
   ,
   output logic [31:0]                         perf_releases,
   output logic [31:0]                         perf_wait_cycles
`endif
);

   function automatic logic [NC_WIDTH:0] popcount(input logic [NUM_CORES-1:0] v);
      logic [NC_WIDTH:0] cnt;
      cnt = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         cnt = cnt + (NC_WIDTH+1)'(v[i]);
      end
      return cnt;
   endfunction

   logic [NUM_CORES-1:0] arrive [NUM_BARRIERS];
   logic [NC_WIDTH-1:0]  rr_ptr;

   logic                 grant_vld_p0;
   logic [NC_WIDTH-1:0]  grant_idx_p0;
   logic [NB_WIDTH-1:0]  sel_id_p0;
   logic [NC_WIDTH-1:0]  sel_core_p0;
   logic [NC_WIDTH-1:0]  sel_size_p0;
   logic [NUM_CORES-1:0] core_bit_p0;
   logic [NUM_CORES-1:0] nxt_mask_p0;
   logic                 dup_p0;
   logic                 rel_p0;
   int                   idx;

   // Stage p0: round-robin grant starting at rr_ptr; no grant while in reset
   always_comb begin
      grant_vld_p0 = 1'b0;
      grant_idx_p0 = '0;
      req_ready    = '0;
      idx          = 0;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_CORES) idx = idx - NUM_CORES;
         if (!grant_vld_p0 && req_valid[idx]) begin
            grant_vld_p0 = 1'b1;
            grant_idx_p0 = NC_WIDTH'(idx);
         end
      end
      if (reset) grant_vld_p0 = 1'b0;
      if (grant_vld_p0) req_ready[grant_idx_p0] = 1'b1;
   end

   always_comb begin
      sel_id_p0   = req_id[grant_idx_p0];
      sel_core_p0 = req_core_id[grant_idx_p0];
      sel_size_p0 = req_size_m1[grant_idx_p0];
      core_bit_p0 = NUM_CORES'(1) << sel_core_p0;
      nxt_mask_p0 = arrive[sel_id_p0] | core_bit_p0;
      dup_p0      = grant_vld_p0 && ((arrive[sel_id_p0] & core_bit_p0) != '0);
      rel_p0      = grant_vld_p0 && !dup_p0 &&
                    (popcount(nxt_mask_p0) == ({1'b0, sel_size_p0} + (NC_WIDTH+1)'(1)));
   end

   // Stage p1: mask update and registered release / duplicate pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NUM_BARRIERS; b++) arrive[b] <= '0;
         rr_ptr    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         dup_err   <= 1'b0;
      end else begin
         rsp_valid <= rel_p0;
         dup_err   <= dup_p0;
         if (rel_p0) rsp_id <= sel_id_p0;
         if (grant_vld_p0) begin
            rr_ptr <= (grant_idx_p0 == NC_WIDTH'(NUM_CORES-1)) ? '0 : grant_idx_p0 + NC_WIDTH'(1);
            if (!dup_p0) arrive[sel_id_p0] <= rel_p0 ? '0 : nxt_mask_p0;
         end
      end
   end

`ifdef GBAR_PERF_EN
   logic any_arrive;

   always_comb begin
      any_arrive = 1'b0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         if (arrive[b] != '0) any_arrive = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_releases    <= '0;
         perf_wait_cycles <= '0;
      end else begin
         if (rel_p0)     perf_releases    <= perf_releases + 32'd1;
         if (any_arrive) perf_wait_cycles <= perf_wait_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vx_gbar_responder.sv
// Bench for vx_gbar_responder: directed arrival sequences, a behavioural
// barrier model compared every cycle, plus literal spot checks.
module tb_vx_gbar_responder;
   localparam int NC = 4;
   localparam int NB = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NC-1:0]     req_valid = '0;
   logic [NC-1:0][2:0] req_id = '0;
   logic [NC-1:0][1:0] req_size_m1 = '0;
   logic [NC-1:0][1:0] req_core_id = '0;
   logic [NC-1:0]     req_ready;
   logic              rsp_valid;
   logic [2:0]        rsp_id;
   logic              dup_err;
`ifdef GBAR_PERF_EN
   logic [31:0]       perf_releases;
   logic [31:0]       perf_wait_cycles;
`endif

   vx_gbar_responder #(.NUM_CORES(NC), .NUM_BARRIERS(NB)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_id(req_id),
      .req_size_m1(req_size_m1), .req_core_id(req_core_id), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .dup_err(dup_err)
`ifdef GBAR_PERF_EN
      , .perf_releases(perf_releases), .perf_wait_cycles(perf_wait_cycles)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: sets of arrived cores per barrier, expected outputs
   int m_mask [NB][NC];
   int m_rr = 0;
   int e_rv = 0, e_rid = 0, e_dup = 0;
   bit started = 0;

   function automatic int model_grant();
      for (int k = 0; k < NC; k++) begin
         int p;
         p = (m_rr + k) % NC;
         if (req_valid[p]) return p;
      end
      return -1;
   endfunction

   function automatic int arrived_count(input int b);
      int n;
      n = 0;
      for (int c = 0; c < NC; c++) n += m_mask[b][c];
      return n;
   endfunction

   always @(posedge clk) begin
      int g, b, c;
      started = 1;
      if (reset) begin
         for (int i = 0; i < NB; i++)
            for (int j = 0; j < NC; j++) m_mask[i][j] = 0;
         m_rr = 0; e_rv = 0; e_rid = 0; e_dup = 0;
      end else begin
         g = model_grant();
         e_rv = 0;
         e_dup = 0;
         if (g >= 0) begin
            b = int'(req_id[g]);
            c = int'(req_core_id[g]);
            m_rr = (g + 1) % NC;
            if (m_mask[b][c] != 0) begin
               e_dup = 1;
            end else begin
               m_mask[b][c] = 1;
               if (arrived_count(b) == int'(req_size_m1[g]) + 1) begin
                  for (int j = 0; j < NC; j++) m_mask[b][j] = 0;
                  e_rv = 1;
                  e_rid = b;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      int g, exp_ready;
      if (started) begin
         g = model_grant();
         exp_ready = (reset || g < 0) ? 0 : (1 << g);
         chk("req_ready", int'(req_ready), exp_ready);
         chk("rsp_valid", int'(rsp_valid), e_rv);
         chk("rsp_id", int'(rsp_id), e_rid);
         chk("dup_err", int'(dup_err), e_dup);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic arrive(input int port, input int id, input int size);
      req_valid = '0;
      req_valid[port] = 1'b1;
      req_id[port] = 3'(id);
      req_size_m1[port] = 2'(size);
      req_core_id[port] = 2'(port);
      step();
      req_valid = '0;
   endtask

   initial begin
      // reset state with every core requesting
      reset = 1'b1;
      req_valid = 4'hF;
      step();
      step();
      chk("reset_ready", int'(req_ready), 0);
      chk("reset_rsp_valid", int'(rsp_valid), 0);
      chk("reset_rsp_id", int'(rsp_id), 0);
      chk("reset_dup", int'(dup_err), 0);
      req_valid = '0;
      reset = 1'b0;
      step();

      // four cores gather on id 2
      arrive(0, 2, 3); chk("b2_after0", int'(rsp_valid), 0);
      arrive(1, 2, 3); chk("b2_after1", int'(rsp_valid), 0);
      arrive(2, 2, 3); chk("b2_after2", int'(rsp_valid), 0);
      arrive(3, 2, 3);
      chk("b2_release", int'(rsp_valid), 1);
      chk("b2_release_id", int'(rsp_id), 2);
`ifdef GBAR_PERF_EN
      chk("perf_releases", int'(perf_releases), 1);
      chk("perf_wait_cycles", int'(perf_wait_cycles), 3);
`endif
      step();
      chk("b2_one_cycle", int'(rsp_valid), 0);
      chk("b2_id_hold", int'(rsp_id), 2);
      // id 2 mask must be empty: a 2-core barrier completes fresh
      arrive(0, 2, 1); chk("b2_rearm0", int'(rsp_valid), 0);
      arrive(1, 2, 1); chk("b2_rearm1", int'(rsp_valid), 1);
      step();

      // round-robin with all cores requesting
      do_reset();
      req_valid = 4'hF;
      for (int i = 0; i < NC; i++) begin
         req_id[i] = 3'd4; req_size_m1[i] = 2'd3; req_core_id[i] = 2'(i);
      end
      #1;
      chk("rr_g0", int'(req_ready), 1); step();
      chk("rr_g1", int'(req_ready), 2); step();
      chk("rr_g2", int'(req_ready), 4); step();
      chk("rr_g3", int'(req_ready), 8); step();
      chk("rr_g0b", int'(req_ready), 1);
      chk("rr_rel", int'(rsp_valid), 1);
      req_valid = '0;
      step();

      // duplicate arrival
      do_reset();
      arrive(1, 0, 1); chk("dup_first", int'(dup_err), 0);
      arrive(1, 0, 1);
      chk("dup_pulse", int'(dup_err), 1);
      chk("dup_norel", int'(rsp_valid), 0);
      arrive(0, 0, 1);
      chk("dup_cleared", int'(dup_err), 0);
      chk("dup_rel", int'(rsp_valid), 1);
      chk("dup_rel_id", int'(rsp_id), 0);
      step();

      // interleaved independent barriers
      arrive(0, 1, 1);
      arrive(1, 5, 1); chk("il_norel", int'(rsp_valid), 0);
      arrive(2, 1, 1); chk("il_rel1", int'(rsp_valid), 1); chk("il_rel1_id", int'(rsp_id), 1);
      arrive(3, 5, 1); chk("il_rel5", int'(rsp_valid), 1); chk("il_rel5_id", int'(rsp_id), 5);
      step();

      // single-core barriers back to back on the same id
      arrive(2, 6, 0); chk("single_rel", int'(rsp_valid), 1); chk("single_id", int'(rsp_id), 6);
      arrive(2, 6, 0); chk("b2b_rel", int'(rsp_valid), 1);
      step();
      chk("b2b_idle", int'(rsp_valid), 0);
      chk("b2b_id_hold", int'(rsp_id), 6);

      // reset discards a partial barrier
      arrive(0, 3, 3);
      arrive(1, 3, 3);
      do_reset();
      arrive(2, 3, 3); chk("rst_part2", int'(rsp_valid), 0);
      arrive(3, 3, 3); chk("rst_part3", int'(rsp_valid), 0);
      arrive(0, 3, 3); chk("rst_part0", int'(rsp_valid), 0);
      arrive(1, 3, 3); chk("rst_rel", int'(rsp_valid), 1); chk("rst_rel_id", int'(rsp_id), 3);
      step();
      chk("rst_once", int'(rsp_valid), 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
